// File: rtl/fifo_to_between.sv
// Transmit side of the 8-bit tsent/trecieve link: pops FIFO bytes, folds them into a
// bit-serial CRC-8 (poly 0x07), drives them onto t0..t7 and appends the CRC every FRAME_LEN bytes.
module fifo_to_between #(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] fifo_dout,
   input  logic       fifo_empty,
   output logic       fifo_re,
   output logic       t0,
   output logic       t1,
   output logic       t2,
   output logic       t3,
   output logic       t4,
   output logic       t5,
   output logic       t6,
   output logic       t7,
   output logic       tsent,
   input  logic       trecieve,
   input  logic       clear_err,
   output logic       isBusy,
   output logic       frame_done,
   output logic [7:0] CRC,
   output logic [3:0] error
);

   localparam int unsigned TmoW = $clog2(TIMEOUT);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
   localparam logic [7:0] FrameLast = 8'(FRAME_LEN - 1);

   typedef enum logic [3:0] {
      StIdle, StRead, StLatch, StCrcSh, StWaitRdy, StDrive, StSend, StRelease, StCrcOut, StAbort
   } state_e;

   state_e          state_q;
   logic [7:0]      byte_q;
   logic [7:0]      data_q;
   logic [7:0]      crc_q;
   logic [7:0]      count_q;
   logic [2:0]      idx_q;
   logic [TmoW-1:0] tmo_q;
   logic            crc_phase_q;
   logic            fifo_re_q;
   logic            tsent_q;
   logic            busy_q;
   logic            frame_done_q;
   logic [3:0]      error_q;

   logic rdy_tmo;
   logic ack_tmo;
   logic en_drop;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
   endfunction

   assign rdy_tmo = enable && (state_q == StWaitRdy) && !trecieve && (tmo_q == TmoLast);
   assign ack_tmo = enable && (state_q == StSend) && trecieve && (tmo_q == TmoLast);
   assign en_drop = !enable && (state_q == StSend);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         byte_q       <= 8'h00;
         data_q       <= 8'h00;
         crc_q        <= 8'h00;
         count_q      <= 8'h00;
         idx_q        <= 3'd0;
         tmo_q        <= '0;
         crc_phase_q  <= 1'b0;
         fifo_re_q    <= 1'b0;
         tsent_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else if (enable) begin
         frame_done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  state_q   <= StRead;
                  fifo_re_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            StRead: begin
               fifo_re_q <= 1'b0;
               state_q   <= StLatch;
            end
            StLatch: begin
               byte_q  <= fifo_dout;
               idx_q   <= 3'd7;
               state_q <= StCrcSh;
            end
            StCrcSh: begin
               crc_q <= crc8_step(crc_q, byte_q[idx_q]);
               idx_q <= idx_q - 3'd1;
               if (idx_q == 3'd0) state_q <= StWaitRdy;
            end
            StWaitRdy: begin
               if (trecieve) begin
                  data_q  <= byte_q;
                  tmo_q   <= '0;
                  state_q <= StDrive;
               end else if (tmo_q == TmoLast) begin
                  tmo_q   <= '0;
                  state_q <= StAbort;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StDrive: begin
               tsent_q <= 1'b1;
               state_q <= StSend;
            end
            StSend: begin
               if (!trecieve) begin
                  tsent_q <= 1'b0;
                  tmo_q   <= '0;
                  state_q <= StRelease;
               end else if (tmo_q == TmoLast) begin
                  tsent_q <= 1'b0;
                  tmo_q   <= '0;
                  state_q <= StAbort;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StRelease: begin
               if (crc_phase_q) begin
                  crc_q        <= 8'h00;
                  count_q      <= 8'h00;
                  crc_phase_q  <= 1'b0;
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end else begin
                  count_q <= count_q + 8'd1;
                  if (count_q == FrameLast) begin
                     state_q <= StCrcOut;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            // The CRC byte goes straight to the handshake; it is never folded into the CRC.
            StCrcOut: begin
               byte_q      <= crc_q;
               crc_phase_q <= 1'b1;
               state_q     <= StWaitRdy;
            end
            StAbort: begin
               crc_q       <= 8'h00;
               count_q     <= 8'h00;
               crc_phase_q <= 1'b0;
               byte_q      <= 8'h00;
               busy_q      <= 1'b0;
               state_q     <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error_q <= 4'h0;
      end else if (clear_err) begin
         error_q <= 4'h0;
      end else begin
         error_q <= error_q | {1'b0, en_drop, rdy_tmo, ack_tmo};
      end
   end

   assign fifo_re    = fifo_re_q;
   assign tsent      = tsent_q;
   assign isBusy     = busy_q;
   assign frame_done = frame_done_q;
   assign CRC        = crc_q;
   assign error      = error_q;
   assign t0         = data_q[7];
   assign t1         = data_q[6];
   assign t2         = data_q[5];
   assign t3         = data_q[4];
   assign t4         = data_q[3];
   assign t5         = data_q[2];
   assign t6         = data_q[1];
   assign t7         = data_q[0];

endmodule

// File: tb/tb_fifo_to_between.sv
// Bench for fifo_to_between: FIFO and receiver models plus a frame-level stream/CRC reference.
module tb_fifo_to_between;

   localparam int unsigned FL = 2;
   localparam int unsigned TO = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] fifo_dout;
   logic       fifo_empty;
   logic       fifo_re;
   logic       t0, t1, t2, t3, t4, t5, t6, t7;
   logic       tsent;
   logic       trecieve;
   logic       clear_err;
   logic       isBusy;
   logic       frame_done;
   logic [7:0] CRC;
   logic [3:0] error;
   logic [7:0] link;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rx_mode = 0;
   int rx_phase = 0;
   int rx_delay = 0;
   int re_count = 0;
   int empty_viol = 0;
   int hold_viol = 0;
   int fd_count = 0;
   logic       tsent_prev = 1'b0;
   logic [7:0] cur_link = 8'h00;

   logic [7:0] fifo_q[$];
   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_crc = 8'h00;
   int         m_cnt = 0;

   always #5 clk = ~clk;
   assign link = {t0, t1, t2, t3, t4, t5, t6, t7};

   fifo_to_between #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .fifo_re(fifo_re), .t0(t0), .t1(t1), .t2(t2), .t3(t3),
      .t4(t4), .t5(t5), .t6(t6), .t7(t7), .tsent(tsent), .trecieve(trecieve),
      .clear_err(clear_err), .isBusy(isBusy), .frame_done(frame_done), .CRC(CRC),
      .error(error)
   );

   // FIFO: data appears the cycle after the pop strobe.
   always @(negedge clk) begin
      if (fifo_re) begin
         re_count++;
         if (fifo_empty) empty_viol++;
         if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
   end

   always @(negedge clk) begin
      case (rx_mode)
         1: trecieve = 1'b0;
         2: trecieve = 1'b1;
         default: begin
            case (rx_phase)
               0: begin
                  trecieve = 1'b1;
                  if (tsent) begin
                     rx_delay = $urandom_range(0, 3);
                     rx_phase = 1;
                  end
               end
               1: begin
                  if (rx_delay == 0) begin
                     trecieve = 1'b0;
                     rx_phase = 2;
                  end else begin
                     rx_delay--;
                  end
               end
               default: begin
                  if (!tsent) begin
                     trecieve = 1'b1;
                     rx_phase = 0;
                  end
               end
            endcase
         end
      endcase
   end

   always @(negedge clk) begin
      cyc++;
      if (frame_done) fd_count++;
      if (tsent && !tsent_prev) begin
         cap_q.push_back(link);
         cur_link = link;
      end else if (tsent && link !== cur_link) begin
         hold_viol++;
      end
      tsent_prev = tsent;
   end

   function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   task automatic model_send(input logic [7:0] d);
      exp_q.push_back(d);
      m_crc = crc_byte(m_crc, d);
      m_cnt++;
      if (m_cnt == FL) begin
         exp_q.push_back(m_crc);
         m_crc = 8'h00;
         m_cnt = 0;
      end
   endtask

   task automatic model_abort();
      m_crc = 8'h00;
      m_cnt = 0;
   endtask

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      model_send(d);
   endtask

   task automatic start_test();
      cap_q.delete();
      exp_q.delete();
      fd_count = 0;
      re_count = 0;
   endtask

   task automatic set_rx(input int mode);
      rx_mode = mode;
      rx_phase = 0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (fifo_q.size() == 0 && !isBusy && cap_q.size() == exp_q.size()) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_re(output int at);
      at = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (fifo_re) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({fifo_re, tsent, isBusy, frame_done, link, CRC, error} !== 23'd0) begin
         failures++;
         $display("FAIL reset_hold: got %h expected 0",
                  {fifo_re, tsent, isBusy, frame_done, link, CRC, error});
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({fifo_re, tsent, isBusy, frame_done, link, CRC, error} !== 23'd0) begin
         failures++;
         $display("FAIL reset_idle: got %h expected 0",
                  {fifo_re, tsent, isBusy, frame_done, link, CRC, error});
      end
   endtask

   task automatic test_single_frame();
      int at;
      int lat;
      bit ok;
      start_test();
      push(8'hA5);
      wait_re(at);
      lat = -1;
      for (int i = 1; i < 100 && at >= 0; i++) begin
         @(negedge clk);
         if (tsent) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat != 12) begin
         failures++;
         $display("FAIL latency: got %0d expected 12", lat);
      end
      wait_done(ok);
      checks++;
      if (CRC !== m_crc) begin
         failures++;
         $display("FAIL partial_crc: got %h expected %h", CRC, m_crc);
      end
      push(8'h3C);
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL single_len: got %0d expected %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL single_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (fd_count != 1 || CRC !== 8'h00) begin
         failures++;
         $display("FAIL single_done: got fd=%0d crc=%h expected fd=1 crc=00", fd_count, CRC);
      end
   endtask

   task automatic test_known_vector();
      bit ok;
      logic [7:0] want[3];
      want = '{8'h01, 8'h02, 8'h1B};
      start_test();
      push(8'h01);
      push(8'h02);
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != 3) begin
         failures++;
         $display("FAIL vector_len: got %0d expected 3", cap_q.size());
      end
      for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== want[i] || cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL vector_byte%0d: got %h expected %h", i, cap_q[i], want[i]);
         end
      end
      checks++;
      if (fd_count != 1 || CRC !== 8'h00) begin
         failures++;
         $display("FAIL vector_done: got fd=%0d crc=%h expected fd=1 crc=00", fd_count, CRC);
      end
   endtask

   task automatic test_random_frames();
      bit ok;
      logic [7:0] d;
      start_test();
      for (int k = 0; k < 3 * FL; k++) begin
         d = 8'($urandom_range(0, 255));
         push(d);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_len: got %0d expected %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (fd_count != 3 || re_count != 3 * FL || empty_viol != 0 || hold_viol != 0) begin
         failures++;
         $display("FAIL random_ctl: got fd=%0d re=%0d ev=%0d hv=%0d expected 3 %0d 0 0",
                  fd_count, re_count, empty_viol, hold_viol, 3 * FL);
      end
   endtask

   task automatic test_ready_timeout();
      int at;
      int n;
      start_test();
      set_rx(1);
      fifo_q.push_back(8'h5A);
      wait_re(at);
      n = -1;
      for (int i = 1; i < 200 && at >= 0; i++) begin
         @(negedge clk);
         if (error[1]) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != 10 + TO || error !== 4'b0010) begin
         failures++;
         $display("FAIL ready_tmo: got n=%0d err=%b expected n=%0d err=0010", n, error, 10 + TO);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (isBusy !== 1'b0 || cap_q.size() != 0 || CRC !== 8'h00) begin
         failures++;
         $display("FAIL ready_after: got busy=%b sent=%0d crc=%h expected 0 0 00",
                  isBusy, cap_q.size(), CRC);
      end
      model_abort();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      checks++;
      if (error !== 4'b0000) begin
         failures++;
         $display("FAIL ready_clear: got %b expected 0000", error);
      end
      set_rx(0);
   endtask

   task automatic test_ack_timeout();
      int at;
      int n;
      bit ok;
      start_test();
      set_rx(2);
      fifo_q.push_back(8'hC3);
      wait_re(at);
      for (int i = 0; i < 100 && at >= 0; i++) begin
         @(negedge clk);
         if (tsent) break;
      end
      n = -1;
      for (int i = 1; i < 200 && tsent; i++) begin
         @(negedge clk);
         if (error[0]) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != TO || error !== 4'b0001 || tsent !== 1'b0) begin
         failures++;
         $display("FAIL ack_tmo: got n=%0d err=%b tsent=%b expected n=%0d err=0001 tsent=0",
                  n, error, tsent, TO);
      end
      model_abort();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      set_rx(0);
      repeat (2) @(negedge clk);
      start_test();
      push(8'($urandom_range(0, 255)));
      push(8'($urandom_range(0, 255)));
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL ack_len: got %0d expected %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL ack_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] d;
      bit ok;
      start_test();
      set_rx(2);
      d = 8'($urandom_range(0, 255));
      push(d);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tsent) break;
      end
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tsent !== 1'b1 || link !== d || error !== 4'b0100 || isBusy !== 1'b1) begin
         failures++;
         $display("FAIL en_hold: got tsent=%b t=%h err=%b expected 1 %h 0100", tsent, link,
                  error, d);
      end
      clear_err = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (error !== 4'b0000) begin
         failures++;
         $display("FAIL en_clear_prio: got %b expected 0000", error);
      end
      clear_err = 1'b0;
      @(negedge clk);
      checks++;
      if (error !== 4'b0100) begin
         failures++;
         $display("FAIL en_reset_err: got %b expected 0100", error);
      end
      set_rx(0);
      enable = 1'b1;
      wait_done(ok);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      push(8'($urandom_range(0, 255)));
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != exp_q.size() || error !== 4'b0000) begin
         failures++;
         $display("FAIL en_len: got %0d err=%b expected %0d err=0000", cap_q.size(), error,
                  exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL en_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_send();
      bit ok;
      start_test();
      set_rx(2);
      push(8'($urandom_range(1, 255)));
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tsent) break;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({tsent, fifo_re, isBusy, CRC, error} !== 15'd0) begin
         failures++;
         $display("FAIL mid_reset: got %h expected 0", {tsent, fifo_re, isBusy, CRC, error});
      end
      @(negedge clk);
      reset = 1'b1;
      model_abort();
      set_rx(0);
      start_test();
      push(8'($urandom_range(0, 255)));
      push(8'($urandom_range(0, 255)));
      wait_done(ok);
      checks++;
      if (!ok || cap_q.size() != exp_q.size() || fd_count != 1) begin
         failures++;
         $display("FAIL restart_len: got %0d fd=%0d expected %0d fd=1", cap_q.size(), fd_count,
                  exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL restart_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      clear_err = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout = 8'h00;
      trecieve = 1'b1;
      #1;
      reset = 1'b0;
      test_reset();
      test_single_frame();
      test_known_vector();
      test_random_frames();
      test_ready_timeout();
      test_ack_timeout();
      test_enable_drop();
      test_reset_mid_send();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
